// File: rtl/lcd_seq_ctrl.sv
// rtl/lcd_seq_ctrl.sv - character LCD power-on init, config and continuous/on-demand redraw sequencer
module lcd_seq_ctrl #(
   parameter int T_15MS   = 750000,
   parameter int T_4_1MS  = 205000,
   parameter int T_100US  = 5000,
   parameter int T_40US   = 2000,
   parameter int T_1_64MS = 82000,
   parameter int T_E      = 12,
   parameter int ROWS     = 2,
   parameter int COLS     = 16,
   parameter int ONESHOT  = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       trans_end,
   input  logic       refresh_req,
   output logic [3:0] SF_D,
   output logic       LCD_E,
   output logic       trans_act,
   output logic [2:0] op_sel,
   output logic       addr_act,
   output logic [6:0] ddram_addr,
   output logic [5:0] char_idx,
   output logic       init_done,
   output logic       frame_done
);

   localparam int CW    = 24;
   localparam int NCHAR = ROWS * COLS;

   typedef enum logic [4:0] {
      S_WAIT15     = 5'd0,
      S_E3A        = 5'd1,
      S_WAIT4_1    = 5'd2,
      S_E3B        = 5'd3,
      S_WAIT100    = 5'd4,
      S_E3C        = 5'd5,
      S_WAIT40A    = 5'd6,
      S_E2         = 5'd7,
      S_WAIT40B    = 5'd8,
      S_FUNC_SET   = 5'd9,
      S_ENTRY_MODE = 5'd10,
      S_DISP_ON    = 5'd11,
      S_CLEAR      = 5'd12,
      S_WAIT1_64   = 5'd13,
      S_SET_ADDR   = 5'd14,
      S_WRITE      = 5'd15,
      S_READY      = 5'd16
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    char_q, char_d;
   logic [5:0]    col_q, col_d;
   logic          row_q, row_d;
   logic          pending_q, pending_d;
   logic          fdone_q, fdone_d;
   logic          cnt_zero;
   logic          last_char;
   logic          wrap;
   logic          pend_eff;

   // Reload value for the shared timer: every timed state runs for T cycles, so T-1 is loaded on entry.
   function automatic logic [CW-1:0] load_val(input state_t s);
      case (s)
         S_WAIT15:                 load_val = CW'(T_15MS - 1);
         S_E3A, S_E3B, S_E3C, S_E2: load_val = CW'(T_E - 1);
         S_WAIT4_1:                load_val = CW'(T_4_1MS - 1);
         S_WAIT100:                load_val = CW'(T_100US - 1);
         S_WAIT40A, S_WAIT40B:     load_val = CW'(T_40US - 1);
         S_WAIT1_64:               load_val = CW'(T_1_64MS - 1);
         default:                  load_val = '0;
      endcase
   endfunction

   assign cnt_zero  = (cnt_q == '0);
   assign last_char = (char_q == 6'(NCHAR - 1));
   assign wrap      = (state_q == S_WRITE) && trans_end && last_char;
   // A request arriving in the very cycle of the wrap counts as pending.
   assign pend_eff  = pending_q | refresh_req;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_WAIT15;
      else        state_q <= state_d;
   end

   // Next-state logic; trans_end only matters in states that are actually requesting a transfer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT15:     if (cnt_zero) state_d = S_E3A;
         S_E3A:        if (cnt_zero) state_d = S_WAIT4_1;
         S_WAIT4_1:    if (cnt_zero) state_d = S_E3B;
         S_E3B:        if (cnt_zero) state_d = S_WAIT100;
         S_WAIT100:    if (cnt_zero) state_d = S_E3C;
         S_E3C:        if (cnt_zero) state_d = S_WAIT40A;
         S_WAIT40A:    if (cnt_zero) state_d = S_E2;
         S_E2:         if (cnt_zero) state_d = S_WAIT40B;
         S_WAIT40B:    if (cnt_zero) state_d = S_FUNC_SET;
         S_FUNC_SET:   if (trans_end) state_d = S_ENTRY_MODE;
         S_ENTRY_MODE: if (trans_end) state_d = S_DISP_ON;
         S_DISP_ON:    if (trans_end) state_d = S_CLEAR;
         S_CLEAR:      if (trans_end) state_d = S_WAIT1_64;
         S_WAIT1_64:   if (cnt_zero) state_d = S_SET_ADDR;
         S_SET_ADDR:   if (trans_end) state_d = S_WRITE;
         S_WRITE: begin
            if (trans_end) begin
               if (!last_char)                    state_d = S_SET_ADDR;
               else if (ONESHOT == 0 || pend_eff) state_d = S_SET_ADDR;
               else                               state_d = S_READY;
            end
         end
         S_READY:      if (refresh_req) state_d = S_SET_ADDR;
         default:      state_d = S_WAIT15;
      endcase
   end

   // Shared down-counter: reload on any state change, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = load_val(state_d);
      else if (!cnt_zero)     cnt_d = cnt_q - CW'(1);
   end

   // Character position, pending-refresh flag and frame-done pulse.
   always_comb begin
      char_d    = char_q;
      col_d     = col_q;
      row_d     = row_q;
      pending_d = pending_q;
      fdone_d   = 1'b0;
      if (state_q == S_WRITE && trans_end) begin
         if (last_char) begin
            char_d  = '0;
            col_d   = '0;
            row_d   = 1'b0;
            fdone_d = 1'b1;
         end else begin
            char_d = char_q + 6'd1;
            if (col_q == 6'(COLS - 1)) begin
               col_d = '0;
               row_d = 1'b1;
            end else begin
               col_d = col_q + 6'd1;
            end
         end
      end
      if (wrap) begin
         pending_d = 1'b0;
      end else if (ONESHOT != 0 && refresh_req &&
                   (state_q == S_SET_ADDR || state_q == S_WRITE)) begin
         pending_d = 1'b1;
      end
   end

   // Datapath registers, including the timer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q     <= load_val(S_WAIT15);
         char_q    <= '0;
         col_q     <= '0;
         row_q     <= 1'b0;
         pending_q <= 1'b0;
         fdone_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         char_q    <= char_d;
         col_q     <= col_d;
         row_q     <= row_d;
         pending_q <= pending_d;
         fdone_q   <= fdone_d;
      end
   end

   // Moore output decode; idle and wait states leave every strobe low.
   always_comb begin
      SF_D      = 4'b0000;
      LCD_E     = 1'b0;
      trans_act = 1'b0;
      op_sel    = 3'b000;
      addr_act  = 1'b0;
      init_done = 1'b0;
      case (state_q)
         S_E3A, S_E3B, S_E3C: begin
            SF_D  = 4'b0011;
            LCD_E = 1'b1;
         end
         S_E2: begin
            SF_D  = 4'b0010;
            LCD_E = 1'b1;
         end
         S_FUNC_SET: begin
            trans_act = 1'b1;
            op_sel    = 3'b010;
         end
         S_ENTRY_MODE: begin
            trans_act = 1'b1;
            op_sel    = 3'b001;
         end
         S_DISP_ON: begin
            trans_act = 1'b1;
            op_sel    = 3'b101;
         end
         S_CLEAR: begin
            trans_act = 1'b1;
            op_sel    = 3'b000;
         end
         S_SET_ADDR: begin
            trans_act = 1'b1;
            op_sel    = 3'b011;
            addr_act  = 1'b1;
            init_done = 1'b1;
         end
         S_WRITE: begin
            trans_act = 1'b1;
            op_sel    = 3'b100;
            init_done = 1'b1;
         end
         S_READY: init_done = 1'b1;
         default: ;
      endcase
   end

   assign ddram_addr = row_q ? (7'h40 | {1'b0, col_q}) : {1'b0, col_q};
   assign char_idx   = char_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb/tb_lcd_seq_ctrl.sv - self-checking bench for lcd_seq_ctrl
module tb_lcd_seq_ctrl;

   localparam int ROWS  = 2;
   localparam int COLS  = 4;
   localparam int NCHAR = ROWS * COLS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, te0, rq0, rst1, te1, rq1;
   logic [3:0] d0_sf, d1_sf;
   logic       d0_e, d1_e, d0_ta, d1_ta, d0_aa, d1_aa, d0_id, d1_id, d0_fd, d1_fd;
   logic [2:0] d0_op, d1_op;
   logic [6:0] d0_addr, d1_addr;
   logic [5:0] d0_idx, d1_idx;

   lcd_seq_ctrl #(.T_15MS(20), .T_4_1MS(10), .T_100US(6), .T_40US(4), .T_1_64MS(8),
                  .T_E(3), .ROWS(ROWS), .COLS(COLS), .ONESHOT(0)) u_dut0 (
      .clk(clk), .reset(rst0), .trans_end(te0), .refresh_req(rq0),
      .SF_D(d0_sf), .LCD_E(d0_e), .trans_act(d0_ta), .op_sel(d0_op), .addr_act(d0_aa),
      .ddram_addr(d0_addr), .char_idx(d0_idx), .init_done(d0_id), .frame_done(d0_fd));

   lcd_seq_ctrl #(.T_15MS(20), .T_4_1MS(10), .T_100US(6), .T_40US(4), .T_1_64MS(8),
                  .T_E(3), .ROWS(ROWS), .COLS(COLS), .ONESHOT(1)) u_dut1 (
      .clk(clk), .reset(rst1), .trans_end(te1), .refresh_req(rq1),
      .SF_D(d1_sf), .LCD_E(d1_e), .trans_act(d1_ta), .op_sel(d1_op), .addr_act(d1_aa),
      .ddram_addr(d1_addr), .char_idx(d1_idx), .init_done(d1_id), .frame_done(d1_fd));

   typedef struct {
      logic [2:0] op;
      logic [6:0] addr;
      logic [5:0] idx;
   } exp_t;

   typedef struct {
      logic [3:0] sf;
      logic       e;
      logic       ta;
      int         len;
      bit         inj;
   } iv_t;

   exp_t sb_q[$];
   iv_t  itab[9];
   int   n_chk = 0, n_pass = 0;
   int   age0 = 0, age1 = 0, fd0_cnt = 0, fd1_cnt = 0;
   bit   sb_on0 = 1'b0, inj0 = 1'b0, prev_last0 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      else n_pass++;
   endtask

   // One clock: sample just after the edge, check, then drive the transmit responders.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (d0_fd || prev_last0) chk("frame_done0_pulse", 32'(d0_fd), 32'(prev_last0));
      if (d0_fd) fd0_cnt++;
      if (d1_fd) fd1_cnt++;
      if (sb_on0 && d0_ta && age0 == 0) begin
         if (sb_q.size() == 0) chk("sb_unexpected_txn", 32'(d0_op), 32'hFFFF);
         else begin
            e = sb_q.pop_front();
            chk("sb_txn", {d0_op, d0_aa, d0_addr, d0_idx},
                {e.op, (e.op == 3'b011), e.addr, e.idx});
         end
      end
      te0 = 1'b0;
      if (d0_ta) begin
         if (age0 == 1) begin te0 = 1'b1; age0 = 0; end
         else age0++;
      end else age0 = 0;
      te0 = te0 | inj0;
      prev_last0 = te0 && d0_ta && d0_op == 3'b100 && d0_idx == 6'(NCHAR - 1);
      te1 = 1'b0;
      if (d1_ta) begin
         if (age1 == 1) begin te1 = 1'b1; age1 = 0; end
         else age1++;
      end else age1 = 0;
   endtask

   task automatic push_cfg();
      sb_q.push_back('{3'b010, 7'h00, 6'd0});
      sb_q.push_back('{3'b001, 7'h00, 6'd0});
      sb_q.push_back('{3'b101, 7'h00, 6'd0});
      sb_q.push_back('{3'b000, 7'h00, 6'd0});
   endtask

   task automatic push_frame();
      for (int i = 0; i < NCHAR; i++) begin
         logic [6:0] a;
         a = 7'((i / COLS) * 64 + (i % COLS));
         sb_q.push_back('{3'b011, a, 6'(i)});
         sb_q.push_back('{3'b100, a, 6'(i)});
      end
   endtask

   // Walk the init table: each record must hold for exactly len cycles.
   task automatic run_init(input bit use_inj);
      for (int i = 0; i < 9; i++) begin
         int n;
         n = 0;
         while ({d0_sf, d0_e, d0_ta} == {itab[i].sf, itab[i].e, itab[i].ta} && n < 100) begin
            n++;
            if (use_inj && itab[i].inj && n == 2) inj0 = 1'b1;
            tick();
            inj0 = 1'b0;
         end
         chk($sformatf("init_seg%0d_len", i), 32'(n), 32'(itab[i].len));
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < 400) begin tick(); n++; end
      chk(name, 32'(sb_q.size()), 0);
   endtask

   initial begin
      int n;
      rst0 = 1'b0; rst1 = 1'b0; te0 = 1'b0; te1 = 1'b0; rq0 = 1'b0; rq1 = 1'b0;
      itab[0] = '{4'h0, 1'b0, 1'b0, 20, 1'b0};
      itab[1] = '{4'h3, 1'b1, 1'b0, 3,  1'b0};
      itab[2] = '{4'h0, 1'b0, 1'b0, 10, 1'b0};
      itab[3] = '{4'h3, 1'b1, 1'b0, 3,  1'b0};
      itab[4] = '{4'h0, 1'b0, 1'b0, 6,  1'b0};
      itab[5] = '{4'h3, 1'b1, 1'b0, 3,  1'b0};
      itab[6] = '{4'h0, 1'b0, 1'b0, 4,  1'b1};
      itab[7] = '{4'h2, 1'b1, 1'b0, 3,  1'b0};
      itab[8] = '{4'h0, 1'b0, 1'b0, 4,  1'b0};

      repeat (3) tick();
      chk("reset_outputs0", {d0_sf, d0_e, d0_ta, d0_op, d0_aa, d0_addr, d0_idx, d0_id, d0_fd}, 0);
      chk("reset_outputs1", {d1_sf, d1_e, d1_ta, d1_op, d1_aa, d1_addr, d1_idx, d1_id, d1_fd}, 0);

      push_cfg();
      push_frame();
      push_frame();
      sb_q.push_back('{3'b011, 7'h00, 6'd0});
      sb_on0 = 1'b1;
      rst0 = 1'b1; rst1 = 1'b1;
      run_init(1'b1);

      // Refresh while dut1 is still configuring must be dropped.
      rq1 = 1'b1; tick(); rq1 = 1'b0;

      n = 0;
      while (!(d0_ta && d0_op == 3'b000) && n < 50) begin tick(); n++; end
      chk("clear_seen", 32'(d0_ta && d0_op == 3'b000), 1);
      chk("init_done_low_in_cfg", 32'(d0_id), 0);
      n = 0;
      while (d0_ta && n < 50) begin tick(); n++; end
      n = 0;
      while (!d0_ta && n < 50) begin tick(); n++; end
      chk("clear_wait_cycles", 32'(n), 8);
      chk("init_done_rise", {d0_id, d0_op, d0_addr}, {1'b1, 3'b011, 7'h00});

      drain("sb_two_frames");
      sb_on0 = 1'b0;
      chk("frame_done0_count", 32'(fd0_cnt), 2);

      chk("oneshot_frame_count", 32'(fd1_cnt), 1);
      n = 0;
      repeat (40) begin
         if (!d1_ta && d1_id && d1_op == 3'b000) n++;
         tick();
      end
      chk("oneshot_ready_hold", 32'(n), 40);

      rq1 = 1'b1; tick(); rq1 = 1'b0;
      chk("refresh_start", {d1_ta, d1_op, d1_idx}, {1'b1, 3'b011, 6'd0});

      n = 0;
      while (!(d1_ta && d1_idx == 6'd2) && n < 100) begin tick(); n++; end
      chk("reach_char2", 32'(d1_idx), 2);
      rq1 = 1'b1; tick(); rq1 = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!d1_fd && n < 100);
      chk("pending_no_stall", {d1_fd, d1_ta, d1_op, d1_idx}, {1'b1, 1'b1, 3'b011, 6'd0});
      n = 0;
      do begin tick(); n++; end while (!d1_fd && n < 100);
      chk("frame_end_ready", {d1_fd, d1_ta, d1_id}, {1'b1, 1'b0, 1'b1});
      n = 0;
      repeat (30) begin
         tick();
         if (!d1_ta) n++;
      end
      chk("ready_hold_after", 32'(n), 30);

      n = 0;
      while (!(d0_ta && d0_op == 3'b100 && d0_idx == 6'd5) && n < 100) begin tick(); n++; end
      chk("reach_write5", {d0_ta, d0_op, d0_idx}, {1'b1, 3'b100, 6'd5});
      rst0 = 1'b0;
      sb_q.delete();
      push_cfg();
      sb_q.push_back('{3'b011, 7'h00, 6'd0});
      tick();
      chk("midreset_outputs", {d0_sf, d0_e, d0_ta, d0_op, d0_aa, d0_addr, d0_idx, d0_id, d0_fd}, 0);
      sb_on0 = 1'b1;
      rst0 = 1'b1;
      run_init(1'b0);
      drain("sb_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
